pipe_control: RTL and testbench

PIPE_CONTROL -- requirements
Module: pipe_control

---
 rtl/pipe_control.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_pipe_control.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_control.sv
// pipe_control: ID-stage decode, load-use / mult-div hazard detection,
// ID/EX control register and the mult/div occupancy tracker.
module pipe_control #(
    parameter int ALUOP_W       = 4,
    parameter int MULDIV_CYCLES = 32,   // legal range 2..255
    parameter int EN_MULDIV     = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               id_valid,
    input  logic [31:0]        id_instr,
    input  logic               ex_memread,
    input  logic [4:0]         ex_rt,
    input  logic               ex_flush,
    output logic               stall,
    output logic               ex_valid,
    output logic               ex_regwrite,
    output logic               ex_memread_o,
    output logic               ex_memwrite,
    output logic [1:0]         ex_regdst,
    output logic [1:0]         ex_memtoreg,
    output logic [1:0]         ex_pcsrc,
    output logic               ex_alusrc1,
    output logic               ex_alusrc2,
    output logic               ex_extop,
    output logic               ex_luop,
    output logic               ex_branch,
    output logic [ALUOP_W-1:0] ex_aluop,
    output logic               ex_muldiv_start,
    output logic               muldiv_busy,
    output logic               exc_illegal
);

    localparam logic       MD_EN    = (EN_MULDIV != 0);
    localparam logic [7:0] CNT_LOAD = 8'(MULDIV_CYCLES - 1);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_JR   = 6'h08;
    localparam logic [5:0] F_JALR = 6'h09;
    localparam logic [5:0] F_MFHI = 6'h10;
    localparam logic [5:0] F_MFLO = 6'h12;
    localparam logic [5:0] F_MULT = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV  = 6'h1A;
    localparam logic [5:0] F_DIVU = 6'h1B;

    // regdst: 00 rt, 01 rd, 10 $ra; memtoreg: 00 alu, 01 mem, 10 pc+4, 11 hi/lo;
    // pcsrc: 00 sequential, 01 branch, 10 jump target, 11 register
    typedef struct packed {
        logic               valid;
        logic               regwrite;
        logic               memread;
        logic               memwrite;
        logic [1:0]         regdst;
        logic [1:0]         memtoreg;
        logic [1:0]         pcsrc;
        logic               alusrc1;
        logic               alusrc2;
        logic               extop;
        logic               luop;
        logic               branch;
        logic [ALUOP_W-1:0] aluop;
        logic               muldiv_start;
    } ctrl_t;

    typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} md_state_t;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       unused_instr_bits;

    ctrl_t      dec;
    logic       dec_legal;
    logic       dec_reads_rt;
    logic       load_use;
    logic       md_use;

    ctrl_t      ctrl_d, ctrl_q;
    logic       exc_illegal_d, exc_illegal_q;

    md_state_t  state_d, state_q;
    logic [7:0] cnt_d, cnt_q;

    assign opcode = id_instr[31:26];
    assign rs     = id_instr[25:21];
    assign rt     = id_instr[20:16];
    assign funct  = id_instr[5:0];
    assign unused_instr_bits = ^id_instr[15:6];

    // Instruction decode into EX control fields plus legality and rt-usage
    always_comb begin
        dec          = '0;
        dec_legal    = 1'b0;
        dec_reads_rt = 1'b0;
        dec.aluop[3] = opcode[0];
        case (opcode)
            OP_RTYPE: begin
                dec_reads_rt     = 1'b1;
                dec.aluop[2:0]   = 3'b010;
                dec.regdst       = 2'b01;
                case (funct)
                    F_SLL, F_SRL, F_SRA: begin
                        dec_legal    = 1'b1;
                        dec.regwrite = 1'b1;
                        dec.alusrc1  = 1'b1;
                    end
                    F_JR: begin
                        dec_legal = 1'b1;
                        dec.pcsrc = 2'b11;
                    end
                    F_JALR: begin
                        dec_legal    = 1'b1;
                        dec.regwrite = 1'b1;
                        dec.memtoreg = 2'b10;
                        dec.pcsrc    = 2'b11;
                    end
                    F_MFHI, F_MFLO: begin
                        dec_legal    = MD_EN;
                        dec.regwrite = 1'b1;
                        dec.memtoreg = 2'b11;
                    end
                    F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                        dec_legal        = MD_EN;
                        dec.muldiv_start = MD_EN;
                    end
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                    6'h2A, 6'h2B: begin
                        dec_legal    = 1'b1;
                        dec.regwrite = 1'b1;
                    end
                    default: ;
                endcase
            end
            OP_LW: begin
                dec_legal    = 1'b1;
                dec.regwrite = 1'b1;
                dec.memread  = 1'b1;
                dec.memtoreg = 2'b01;
                dec.alusrc2  = 1'b1;
                dec.extop    = 1'b1;
            end
            OP_SW: begin
                dec_legal    = 1'b1;
                dec_reads_rt = 1'b1;
                dec.memwrite = 1'b1;
                dec.alusrc2  = 1'b1;
                dec.extop    = 1'b1;
            end
            OP_LUI: begin
                dec_legal    = 1'b1;
                dec.regwrite = 1'b1;
                dec.alusrc2  = 1'b1;
                dec.luop     = 1'b1;
            end
            OP_ADDI, OP_ADDIU: begin
                dec_legal    = 1'b1;
                dec.regwrite = 1'b1;
                dec.alusrc2  = 1'b1;
                dec.extop    = 1'b1;
            end
            OP_SLTI, OP_SLTIU: begin
                dec_legal      = 1'b1;
                dec.regwrite   = 1'b1;
                dec.alusrc2    = 1'b1;
                dec.extop      = 1'b1;
                dec.aluop[2:0] = 3'b101;
            end
            OP_ANDI: begin
                dec_legal      = 1'b1;
                dec.regwrite   = 1'b1;
                dec.alusrc2    = 1'b1;
                dec.aluop[2:0] = 3'b100;
            end
            OP_BEQ: begin
                dec_legal      = 1'b1;
                dec_reads_rt   = 1'b1;
                dec.branch     = 1'b1;
                dec.extop      = 1'b1;
                dec.pcsrc      = 2'b01;
                dec.aluop[2:0] = 3'b001;
            end
            OP_J: begin
                dec_legal = 1'b1;
                dec.pcsrc = 2'b10;
            end
            OP_JAL: begin
                dec_legal    = 1'b1;
                dec.regwrite = 1'b1;
                dec.regdst   = 2'b10;
                dec.memtoreg = 2'b10;
                dec.pcsrc    = 2'b10;
            end
            default: ;
        endcase
    end

    // Hazard detection; a taken branch/jump in EX overrides any stall since ID is squashed
    always_comb begin
        load_use = id_valid && ex_memread && (ex_rt != 5'd0) &&
                   ((ex_rt == rs) || (dec_reads_rt && (ex_rt == rt)));
        md_use   = id_valid && muldiv_busy && (opcode == OP_RTYPE) &&
                   ((funct == F_MFHI) || (funct == F_MFLO) ||
                    (funct == F_MULT) || (funct == F_MULTU) ||
                    (funct == F_DIV)  || (funct == F_DIVU));
        stall    = !ex_flush && (load_use || md_use);
    end

    // ID/EX next value: bubble on flush, stall, empty ID or illegal instruction
    always_comb begin
        ctrl_d        = '0;
        exc_illegal_d = 1'b0;
        if (!ex_flush && !stall && id_valid) begin
            if (dec_legal) begin
                ctrl_d       = dec;
                ctrl_d.valid = 1'b1;
            end else begin
                exc_illegal_d = 1'b1;
            end
        end
    end

    // ID/EX control register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q        <= '0;
            exc_illegal_q <= 1'b0;
        end else begin
            ctrl_q        <= ctrl_d;
            exc_illegal_q <= exc_illegal_d;
        end
    end

    // Mult/div tracker: state and counter register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Mult/div tracker: next state; a flush never cuts a running operation short
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (ctrl_q.muldiv_start) begin
                    state_d = S_BUSY;
                    cnt_d   = CNT_LOAD;
                end
            end
            S_BUSY: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Mult/div tracker: outputs
    always_comb begin
        muldiv_busy = (state_q == S_BUSY);
    end

    assign ex_valid        = ctrl_q.valid;
    assign ex_regwrite     = ctrl_q.regwrite;
    assign ex_memread_o    = ctrl_q.memread;
    assign ex_memwrite     = ctrl_q.memwrite;
    assign ex_regdst       = ctrl_q.regdst;
    assign ex_memtoreg     = ctrl_q.memtoreg;
    assign ex_pcsrc        = ctrl_q.pcsrc;
    assign ex_alusrc1      = ctrl_q.alusrc1;
    assign ex_alusrc2      = ctrl_q.alusrc2;
    assign ex_extop        = ctrl_q.extop;
    assign ex_luop         = ctrl_q.luop;
    assign ex_branch       = ctrl_q.branch;
    assign ex_aluop        = ctrl_q.aluop;
    assign ex_muldiv_start = ctrl_q.muldiv_start;
    assign exc_illegal     = exc_illegal_q;

endmodule

// File: tb/tb_pipe_control.sv
// tb_pipe_control: directed and randomized checks of pipe_control against a
// cycle-level reference model of the pipeline control rules.
module tb_pipe_control;

    localparam int N = 6;   // mult/div latency used for the bench

    logic        clk = 1'b0;
    logic        reset_n;
    logic        id_valid;
    logic [31:0] id_instr;
    logic        ex_memread;
    logic [4:0]  ex_rt;
    logic        ex_flush;

    logic       stall, ex_valid, ex_regwrite, ex_memread_o, ex_memwrite;
    logic [1:0] ex_regdst, ex_memtoreg, ex_pcsrc;
    logic       ex_alusrc1, ex_alusrc2, ex_extop, ex_luop, ex_branch;
    logic [3:0] ex_aluop;
    logic       ex_muldiv_start, muldiv_busy, exc_illegal;

    logic       n_stall, n_ex_valid, n_ex_regwrite, n_ex_memread_o, n_ex_memwrite;
    logic [1:0] n_ex_regdst, n_ex_memtoreg, n_ex_pcsrc;
    logic       n_ex_alusrc1, n_ex_alusrc2, n_ex_extop, n_ex_luop, n_ex_branch;
    logic [3:0] n_ex_aluop;
    logic       n_ex_muldiv_start, n_muldiv_busy, n_exc_illegal;

    always #5 clk = ~clk;

    pipe_control #(.ALUOP_W(4), .MULDIV_CYCLES(N), .EN_MULDIV(1)) dut (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_instr(id_instr),
        .ex_memread(ex_memread), .ex_rt(ex_rt), .ex_flush(ex_flush),
        .stall(stall), .ex_valid(ex_valid), .ex_regwrite(ex_regwrite),
        .ex_memread_o(ex_memread_o), .ex_memwrite(ex_memwrite),
        .ex_regdst(ex_regdst), .ex_memtoreg(ex_memtoreg), .ex_pcsrc(ex_pcsrc),
        .ex_alusrc1(ex_alusrc1), .ex_alusrc2(ex_alusrc2), .ex_extop(ex_extop),
        .ex_luop(ex_luop), .ex_branch(ex_branch), .ex_aluop(ex_aluop),
        .ex_muldiv_start(ex_muldiv_start), .muldiv_busy(muldiv_busy),
        .exc_illegal(exc_illegal)
    );

    pipe_control #(.ALUOP_W(4), .MULDIV_CYCLES(N), .EN_MULDIV(0)) dut_nomd (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_instr(id_instr),
        .ex_memread(ex_memread), .ex_rt(ex_rt), .ex_flush(ex_flush),
        .stall(n_stall), .ex_valid(n_ex_valid), .ex_regwrite(n_ex_regwrite),
        .ex_memread_o(n_ex_memread_o), .ex_memwrite(n_ex_memwrite),
        .ex_regdst(n_ex_regdst), .ex_memtoreg(n_ex_memtoreg), .ex_pcsrc(n_ex_pcsrc),
        .ex_alusrc1(n_ex_alusrc1), .ex_alusrc2(n_ex_alusrc2), .ex_extop(n_ex_extop),
        .ex_luop(n_ex_luop), .ex_branch(n_ex_branch), .ex_aluop(n_ex_aluop),
        .ex_muldiv_start(n_ex_muldiv_start), .muldiv_busy(n_muldiv_busy),
        .exc_illegal(n_exc_illegal)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // reference model of what the ID/EX register should hold
    bit       m_valid, m_regwrite, m_memread, m_memwrite, m_branch, m_start, m_illegal;
    bit [3:0] m_aluop;
    int       m_rem;         // remaining busy cycles of the mult/div unit
    logic     obs_stall;

    logic [5:0] fn_tab [26] = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h09, 6'h20, 6'h21,
                                6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A,
                                6'h2B, 6'h10, 6'h12, 6'h18, 6'h19, 6'h1A, 6'h1B,
                                6'h01, 6'h11, 6'h12, 6'h10, 6'h18};
    logic [5:0] op_tab [12] = '{6'h23, 6'h2B, 6'h0F, 6'h08, 6'h09, 6'h0A,
                                6'h0B, 6'h0C, 6'h04, 6'h02, 6'h03, 6'h3F};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Architectural meaning of an instruction in the team's MIPS subset
    function automatic void ref_decode(input logic [31:0] ins, input bit en_md,
                                       output bit legal, output bit rw, output bit mr,
                                       output bit mw, output bit br, output bit [3:0] aop,
                                       output bit md, output bit rdrt);
        logic [5:0] op;
        logic [5:0] fn;
        op = ins[31:26];
        fn = ins[5:0];
        legal = 0; rw = 0; mr = 0; mw = 0; br = 0; md = 0; rdrt = 0;
        aop = {op[0], 3'b000};
        case (op)
            6'h00: begin
                rdrt = 1; aop = 4'b0010;
                if (fn inside {6'h00, 6'h02, 6'h03, 6'h09, [6'h20:6'h27], 6'h2A, 6'h2B}) begin
                    legal = 1; rw = 1;
                end else if (fn == 6'h08) begin
                    legal = 1;
                end else if (fn inside {6'h10, 6'h12}) begin
                    legal = en_md; rw = 1;
                end else if (fn inside {[6'h18:6'h1B]}) begin
                    legal = en_md; md = en_md;
                end
            end
            6'h23: begin legal = 1; rw = 1; mr = 1; end
            6'h2B: begin legal = 1; mw = 1; rdrt = 1; end
            6'h0F, 6'h08, 6'h09, 6'h03: begin legal = 1; rw = 1; end
            6'h0A, 6'h0B: begin legal = 1; rw = 1; aop[2:0] = 3'b101; end
            6'h0C: begin legal = 1; rw = 1; aop[2:0] = 3'b100; end
            6'h04: begin legal = 1; br = 1; rdrt = 1; aop[2:0] = 3'b001; end
            6'h02: legal = 1;
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0] rs;
        logic [4:0] rt;
        rs = 5'($urandom_range(0, 3));
        rt = 5'($urandom_range(0, 3));
        if ($urandom_range(0, 1) == 0)
            return rtype(rs, rt, 5'd9, fn_tab[$urandom_range(0, 25)]);
        return itype(op_tab[$urandom_range(0, 11)], rs, rt, 16'($urandom));
    endfunction

    // One clock cycle: drive ID/EX inputs, check at the falling edge, advance the model
    task automatic cycle(input logic [31:0] ins, input logic v, input logic mr,
                         input logic [4:0] rt, input logic fl);
        bit legal, rw, mrd, mw, br, md, rdrt, lu, mdh, st, bub;
        bit [3:0] aop;
        id_instr = ins; id_valid = v; ex_memread = mr; ex_rt = rt; ex_flush = fl;
        ref_decode(ins, 1'b1, legal, rw, mrd, mw, br, aop, md, rdrt);
        lu  = v && mr && (rt != 0) && ((rt == ins[25:21]) || (rdrt && (rt == ins[20:16])));
        mdh = v && (m_rem != 0) && (ins[31:26] == 6'h00) &&
              (ins[5:0] inside {6'h10, 6'h12, [6'h18:6'h1B]});
        st  = !fl && (lu || mdh);
        @(negedge clk);
        obs_stall = stall;
        $display("cyc %0d instr=%08h v=%0b mr=%0b ex_rt=%0d flush=%0b stall=%0b busy=%0b ex_valid=%0b",
                 cyc, ins, v, mr, rt, fl, stall, muldiv_busy, ex_valid);
        cyc++;
        check("stall", stall, st);
        check("ex_valid", ex_valid, m_valid);
        check("ex_regwrite", ex_regwrite, m_regwrite);
        check("ex_memread_o", ex_memread_o, m_memread);
        check("ex_memwrite", ex_memwrite, m_memwrite);
        check("ex_branch", ex_branch, m_branch);
        check("ex_aluop", ex_aluop, m_aluop);
        check("ex_muldiv_start", ex_muldiv_start, m_start);
        check("exc_illegal", exc_illegal, m_illegal);
        check("muldiv_busy", muldiv_busy, m_rem != 0);
        if (!m_valid)
            check("bubble_fields", {ex_regdst, ex_memtoreg, ex_pcsrc, ex_alusrc1,
                                    ex_alusrc2, ex_extop, ex_luop}, 0);
        if (m_rem > 0) m_rem--;
        else if (m_start) m_rem = N;
        bub        = fl || st || !v || !legal;
        m_illegal  = v && !fl && !st && !legal;
        m_valid    = !bub;
        m_regwrite = !bub && rw;
        m_memread  = !bub && mrd;
        m_memwrite = !bub && mw;
        m_branch   = !bub && br;
        m_aluop    = bub ? 4'b0000 : aop;
        m_start    = !bub && md;
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_valid = 0; m_regwrite = 0; m_memread = 0; m_memwrite = 0; m_branch = 0;
        m_start = 0; m_illegal = 0; m_aluop = 4'b0000; m_rem = 0;
    endtask

    logic [31:0] add_i, mult_i, mflo_i, lw_i;
    int          nstall;

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        add_i  = rtype(5'd8, 5'd10, 5'd9, 6'h20);   // add $t1,$t0,$t2
        mult_i = rtype(5'd8, 5'd9, 5'd0, 6'h18);
        mflo_i = rtype(5'd0, 5'd0, 5'd11, 6'h12);
        lw_i   = itype(6'h23, 5'd29, 5'd8, 16'h0004);
        reset_n = 1'b1; id_valid = 0; id_instr = '0; ex_memread = 0; ex_rt = '0; ex_flush = 0;
        model_clear();
        #1 reset_n = 1'b0;
        #2;
        check("rst_ex_valid", ex_valid, 0);
        check("rst_busy", muldiv_busy, 0);
        check("rst_illegal", exc_illegal, 0);
        check("rst_fields", {ex_regwrite, ex_memread_o, ex_memwrite, ex_regdst, ex_memtoreg,
                             ex_pcsrc, ex_alusrc1, ex_alusrc2, ex_extop, ex_luop, ex_branch,
                             ex_aluop, ex_muldiv_start}, 0);
        id_valid = 1; id_instr = add_i;
        @(posedge clk);
        #3;
        check("rst_held_ex_valid", ex_valid, 0);
        id_valid = 0;
        #4 reset_n = 1'b1;
        @(posedge clk);
        #1;

        // load-use: lw $t0 in EX, add reading $t0 in ID
        cycle(add_i, 1, 1, 5'd8, 0);
        check("r034_stalled", obs_stall, 1);
        check("r034_bubble", ex_valid, 0);
        cycle(add_i, 1, 0, 5'd0, 0);
        check("r034_issue_valid", ex_valid, 1);
        check("r034_issue_rw", ex_regwrite, 1);
        check("r034_issue_aluop", ex_aluop, 4'b0010);

        // $zero destination never hazards
        cycle(rtype(5'd0, 5'd5, 5'd6, 6'h20), 1, 1, 5'd0, 0);
        check("r035_nostall", obs_stall, 0);

        // flush wins over a load-use hazard
        cycle(add_i, 1, 1, 5'd8, 1);
        check("r037_nostall", obs_stall, 0);
        check("r037_valid", ex_valid, 0);
        check("r037_fields", {ex_regwrite, ex_aluop, ex_muldiv_start}, 0);

        // mult then mflo held in ID until the unit frees up
        cycle(mult_i, 1, 0, 5'd0, 0);
        check("r036_start", ex_muldiv_start, 1);
        cycle(32'h0, 0, 0, 5'd0, 0);
        nstall = 0;
        for (int k = 0; k < N + 4; k++) begin
            cycle(mflo_i, 1, 0, 5'd0, 0);
            if (!obs_stall) break;
            nstall++;
        end
        check("r036_stall_cycles", nstall, N);
        check("r036_mflo_issued", ex_regwrite, 1);
        check("r036_busy_done", muldiv_busy, 0);

        // illegal opcode and mult with the unit disabled
        cycle({6'h3F, 26'h0}, 1, 0, 5'd0, 0);
        check("r038_illegal", exc_illegal, 1);
        check("r038_rw", ex_regwrite, 0);
        cycle(32'h0, 0, 0, 5'd0, 0);
        check("r038_pulse_end", exc_illegal, 0);
        cycle(mult_i, 1, 0, 5'd0, 0);
        check("r038_nomd_illegal", n_exc_illegal, 1);
        check("r038_nomd_rw", n_ex_regwrite, 0);
        check("r038_nomd_valid", n_ex_valid, 0);
        check("r038_nomd_start", n_ex_muldiv_start, 0);
        cycle(32'h0, 0, 0, 5'd0, 0);
        check("r038_nomd_pulse_end", n_exc_illegal, 0);

        // asynchronous reset while the unit is busy
        cycle(add_i, 1, 0, 5'd0, 0);
        check("r039_busy_before", muldiv_busy, 1);
        check("r039_valid_before", ex_valid, 1);
        id_instr = lw_i; id_valid = 1;
        #3 reset_n = 1'b0;
        #1;
        check("r039_busy_drop", muldiv_busy, 0);
        check("r039_valid_drop", ex_valid, 0);
        check("r039_fields_drop", {ex_regwrite, ex_aluop}, 0);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("r039_decode_valid", ex_valid, 1);
        check("r039_decode_lw", ex_memread_o, 1);
        check("r039_idle", muldiv_busy, 0);
        model_clear();
        m_valid = 1; m_regwrite = 1; m_memread = 1; m_aluop = 4'b1000;

        // randomized traffic against the model
        for (int i = 0; i < 500; i++) begin
            cycle(rand_instr(), $urandom_range(0, 7) != 0, $urandom_range(0, 2) == 0,
                  5'($urandom_range(0, 3)), $urandom_range(0, 9) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
